mcu_readback_interface: RTL and testbench
=========================================

// Module: mcu_readback_interface
// PURPOSE
//  MCU-side pixel read-back port: lets the host MCU read pixels out of video RAM over the 8-bit register bus.
//  Snoops host writes to the shared X/Y/increment registers, prefetches the addressed pixel through MemoryManager's read handshake, and returns it on a bus read.
//  Auto-advances by the X increment after each data read, so the host can stream a row of pixels.
//  Sits beside the pixel-write interface; both share the MCU bus and the memory request port.
// PARAMETERS
//  ADDR_WIDTH   17  video RAM address width; address = {Y[7:0], X[8:0]}
//  DATA_WIDTH   8   pixel / bus width
//  SYNC_STAGES  2   synchronizer depth on the bus strobe (minimum 2)
// PORTS
//  clock               in     1   system clock
//  reset               in     1   asynchronous, active-high
//  mpuChipSelect       in     1   bus cycle active (high)
//  mpuWriteEnable      in     1   low = host write, high = host read
//  mpuRegisterSelect   in     3   register index
//  mpuDataBus          inout  8   driven only during qualifying reads, else 'z
//  memoryAddress       out    17  read address to MemoryManager
//  memoryReadRequest   out    1   read request, held until complete
//  memoryReadData      in     8   read data, valid while memoryReadComplete=1
//  memoryReadComplete  in     1   MemoryManager read done
// BEHAVIOUR
//  Registers: 0 X_LOW, 1 X_HIGH (bit0 only), 2 Y, 4 X_INCREMENT (all write, snooped);
//   5 READ_DATA (read), 6 STATUS (read: bit0 busy, bit1 valid, others 0), 7 ARM (write, data ignored); reg 3 ignored.
//  Bus drive: mpuDataBus = (cs && we && sel==5) ? dataBuf : (cs && we && sel==6) ? status : 'z.
//   Combinational from the pins, no clock latency; the bus is never driven during writes.
//  Strobe sync: write strobe = cs&&!we and read strobe = cs&&we, each passed through SYNC_STAGES flops.
//   Events fire on the synchronized 1->0 edge, i.e. at the end of the bus cycle.
//   The host must hold sel and data stable for >= SYNC_STAGES+1 clocks after deasserting cs.
//  Write events: update addrNext fields and xInc.
//   ARM: copies addrNext into curAddr, clears valid, and starts a fetch.
//  Read event on sel 5 with valid=1:
//   curAddr <= curAddr + xInc, valid <= 0, fetch starts.
//   Address wraps modulo 2^17; xInc is zero-extended.
//  Read event on sel 5 with valid=0: no state change; the host saw the stale buffer.
//  FSM IDLE -> REQ -> IDLE:
//   fetch start: memoryAddress <= curAddr and memoryReadRequest <= 1 on the next edge; state REQ; busy=1.
//   REQ with memoryReadComplete=1: dataBuf <= memoryReadData, request <= 0 on the same edge, valid <= 1, return to IDLE.
//   The request is held, and memoryAddress is stable, for every cycle until complete.
//  Fetch start while in REQ (ARM or advance):
//   set pending and record the new curAddr; the in-flight result is discarded (valid stays 0).
//   On completion, a new request is issued the next cycle with the latest curAddr.
//  ARM and read event in the same cycle cannot occur (single strobe); if both synced flags fire, ARM wins.
//  Reset (async, any time, including mid-request):
//   memoryReadRequest=0, memoryAddress=0, dataBuf=0, addrNext=0, curAddr=0, xInc=1, valid=0, pending=0, FSM IDLE.
//   The bus is released ('z) unless cs&&we is asserted with sel 5 or 6.
// STRUCTURE
//  g76_video_pkg: register index constants (REG_X_LOW..REG_ARM), ADDR_WIDTH, DATA_WIDTH,
//   rb_state_t enum {IDLE, REQ}, and function make_addr(x, y).
//  Sub-module bus_strobe_sync: SYNC_STAGES flop chain plus falling-edge pulse; one instance per strobe.
//  Top level: register snoop, address/advance logic, fetch FSM, tri-state bus mux.
// TESTING
//  1 Write X_LOW=0xFF, X_HIGH=1, Y=2, then ARM; memory model returns 0xA5 after 3 cycles
//    -> memoryAddress=0x005FF, request held 3 cycles, STATUS=0x02, READ_DATA=0xA5.
//  2 INC=1, ARM at {Y=0,X=0x1FF}, read READ_DATA
//    -> next fetch address=0x00200 (carry into Y); at 0x1FFFF the next address is 0x00000.
//  3 Read READ_DATA while busy (memory stalls 10 cycles)
//    -> bus returns old buffer, STATUS=0x01, no address advance, no extra request.
//  4 ARM at 0x00010, then ARM at 0x00020 before complete
//    -> first data discarded; second request for 0x00020 issued 1 cycle after the first complete; valid only then.
//  5 Assert reset 2 cycles into a request
//    -> memoryReadRequest=0 immediately; STATUS=0x00 after release; no fetch until the next ARM.
//  6 Host writes to any register with cs=1, we=0 -> mpuDataBus never driven by this block (checked 'z every cycle).

Source files
------------

// File: rtl/g76_video_pkg.sv
// Shared register map, bus widths and address helper for the G76 video MCU interfaces.
// Pure definitions: no logic, no latency, no flow control.
package g76_video_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 8;

  localparam logic [2:0] REG_X_LOW     = 3'd0;
  localparam logic [2:0] REG_X_HIGH    = 3'd1;
  localparam logic [2:0] REG_Y         = 3'd2;
  localparam logic [2:0] REG_X_INC     = 3'd4;
  localparam logic [2:0] REG_READ_DATA = 3'd5;
  localparam logic [2:0] REG_STATUS    = 3'd6;
  localparam logic [2:0] REG_ARM       = 3'd7;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_REQ  = 1'b1;

  typedef enum logic {IDLE = STATE_IDLE, REQ = STATE_REQ} rb_state_t;

  // Row-major pixel address: Y selects the 512-pixel row, X the column.
  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [8:0] x, input logic [7:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/bus_strobe_sync.sv
// Synchronizes an async bus strobe and pulses one cycle on its synchronized falling edge.
// Pulse appears SYNC_STAGES+1 clocks after the strobe drops; no backpressure.
module bus_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic fallPulse
);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncLast;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncChain <= '0;
      syncLast  <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], strobe};
      syncLast  <= syncChain[SYNC_STAGES-1];
    end
  end

  assign fallPulse = syncLast & ~syncChain[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_readback_interface.sv
// MCU pixel read-back port: snoops X/Y/INC writes, prefetches the addressed pixel, streams it on reads.
// Bus reads are combinational; fetch holds the request until MemoryManager completes.
import g76_video_pkg::*;

module mcu_readback_interface #(
  parameter int ADDR_WIDTH  = g76_video_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = g76_video_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mpuChipSelect,
  input  logic                  mpuWriteEnable,
  input  logic [2:0]            mpuRegisterSelect,
  inout  wire  [DATA_WIDTH-1:0] mpuDataBus,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic                  memoryReadRequest,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryReadComplete
);

  logic                  writeEvt, readEvt;
  logic [8:0]            xNext;
  logic [7:0]            yNext;
  logic [DATA_WIDTH-1:0] xInc, dataBuf, status;
  logic [ADDR_WIDTH-1:0] curAddr, fetchAddr;
  logic                  valid, pending, state, busy;
  logic                  armEvt, advEvt, fetchStart;

  bus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) uWriteSync (
    .clock     (clock),
    .reset     (reset),
    .strobe    (mpuChipSelect & ~mpuWriteEnable),
    .fallPulse (writeEvt)
  );

  bus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) uReadSync (
    .clock     (clock),
    .reset     (reset),
    .strobe    (mpuChipSelect & mpuWriteEnable),
    .fallPulse (readEvt)
  );

  // Select and data are still held by the host when the delayed edge event fires.
  assign armEvt     = writeEvt && (mpuRegisterSelect == REG_ARM);
  assign advEvt     = readEvt && (mpuRegisterSelect == REG_READ_DATA) && valid && !armEvt;
  assign fetchStart = armEvt || advEvt;
  assign fetchAddr  = armEvt ? make_addr(xNext, yNext)
                             : curAddr + {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, xInc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xNext <= '0;
      yNext <= '0;
      xInc  <= DATA_WIDTH'(1);
    end else if (writeEvt) begin
      case (mpuRegisterSelect)
        REG_X_LOW:  xNext[7:0] <= mpuDataBus[7:0];
        REG_X_HIGH: xNext[8]   <= mpuDataBus[0];
        REG_Y:      yNext      <= mpuDataBus[7:0];
        REG_X_INC:  xInc       <= mpuDataBus;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memoryAddress     <= '0;
      memoryReadRequest <= 1'b0;
      dataBuf           <= '0;
      curAddr           <= '0;
      valid             <= 1'b0;
      pending           <= 1'b0;
      state             <= STATE_IDLE;
    end else begin
      if (fetchStart) begin
        curAddr <= fetchAddr;
        valid   <= 1'b0;
      end
      if (state == STATE_IDLE) begin
        if (fetchStart || pending) begin
          memoryAddress     <= fetchStart ? fetchAddr : curAddr;
          memoryReadRequest <= 1'b1;
          pending           <= 1'b0;
          state             <= STATE_REQ;
        end
      end else begin
        if (fetchStart) pending <= 1'b1;
        if (memoryReadComplete) begin
          memoryReadRequest <= 1'b0;
          state             <= STATE_IDLE;
          // A superseded fetch must not overwrite the buffer or mark it valid.
          if (!pending && !fetchStart) begin
            dataBuf <= memoryReadData;
            valid   <= 1'b1;
          end
        end
      end
    end
  end

  assign busy   = (state == STATE_REQ) || pending;
  assign status = {{(DATA_WIDTH-2){1'b0}}, valid, busy};

  assign mpuDataBus = (mpuChipSelect && mpuWriteEnable && mpuRegisterSelect == REG_READ_DATA) ? dataBuf :
                      (mpuChipSelect && mpuWriteEnable && mpuRegisterSelect == REG_STATUS)    ? status  :
                      {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mcu_readback_interface.sv
// Directed bench for mcu_readback_interface with a latency-programmable memory model.
module tb_mcu_readback_interface;

  logic        clock;
  logic        reset;
  logic        mpuChipSelect;
  logic        mpuWriteEnable;
  logic [2:0]  mpuRegisterSelect;
  tri1  [7:0]  mpuDataBus;
  logic [16:0] memoryAddress;
  logic        memoryReadRequest;
  logic [7:0]  memoryReadData;
  logic        memoryReadComplete;

  logic        tbDrive;
  logic [7:0]  tbData;
  assign mpuDataBus = tbDrive ? tbData : 8'hzz;

  int checks = 0;
  int failures = 0;

  int          memLatency = 3;
  int          holdCnt = 0;
  int          lastHold = 0;
  int          reqCount = 0;
  int          stabErr = 0;
  logic        prevReq = 1'b0;
  logic [16:0] prevAddr = '0;
  logic [16:0] lastReqAddr = '0;

  mcu_readback_interface dut (
    .clock              (clock),
    .reset              (reset),
    .mpuChipSelect      (mpuChipSelect),
    .mpuWriteEnable     (mpuWriteEnable),
    .mpuRegisterSelect  (mpuRegisterSelect),
    .mpuDataBus         (mpuDataBus),
    .memoryAddress      (memoryAddress),
    .memoryReadRequest  (memoryReadRequest),
    .memoryReadData     (memoryReadData),
    .memoryReadComplete (memoryReadComplete)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: completes after memLatency cycles of held request; data = addr[7:0] ^ 0x5A.
  initial begin
    memoryReadComplete = 1'b0;
    memoryReadData = 8'h00;
    forever begin
      @(negedge clock);
      if (memoryReadComplete) begin
        memoryReadComplete = 1'b0;
        holdCnt = 0;
      end else if (memoryReadRequest && !reset) begin
        if (!prevReq) reqCount++;
        else if (memoryAddress !== prevAddr) stabErr++;
        holdCnt++;
        if (holdCnt >= memLatency) begin
          memoryReadComplete = 1'b1;
          memoryReadData = memoryAddress[7:0] ^ 8'h5A;
          lastReqAddr = memoryAddress;
          lastHold = holdCnt;
        end
      end else begin
        holdCnt = 0;
      end
      prevReq = memoryReadRequest;
      prevAddr = memoryAddress;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic hostWrite(input logic [2:0] sel, input logic [7:0] data);
    mpuChipSelect = 1'b1; mpuWriteEnable = 1'b0; mpuRegisterSelect = sel;
    tbData = data; tbDrive = 1'b1;
    repeat (2) tick();
    mpuChipSelect = 1'b0;
    repeat (4) tick();
    tbDrive = 1'b0;
  endtask

  task automatic hostRead(input logic [2:0] sel, output logic [7:0] data);
    mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1; mpuRegisterSelect = sel;
    #1 data = mpuDataBus;
    repeat (2) tick();
    mpuChipSelect = 1'b0;
    mpuWriteEnable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((memoryReadRequest || memoryReadComplete) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s: fetch still active after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (memoryReadRequest !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", memoryReadRequest); end
    checks++;
    if (memoryAddress !== 17'h0) begin failures++; $display("FAIL reset_addr: got %h want 00000", memoryAddress); end
    checks++;
    if (mpuDataBus !== 8'hFF) begin failures++; $display("FAIL reset_bus_released: got %h want ff (pulled up)", mpuDataBus); end
    hostRead(3'd6, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_status: got %h want 00", d); end
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_databuf: got %h want 00", d); end
  endtask

  task automatic test_basic_fetch();
    logic [7:0] d;
    memLatency = 3;
    hostWrite(3'd0, 8'hFF);
    hostWrite(3'd1, 8'h01);
    hostWrite(3'd2, 8'h02);
    hostWrite(3'd7, 8'h00);
    checks++;
    if (memoryReadRequest !== 1'b1 || memoryAddress !== 17'h005FF) begin
      failures++;
      $display("FAIL basic_req: got req=%b addr=%h want req=1 addr=005ff", memoryReadRequest, memoryAddress);
    end
    waitIdle("basic_idle");
    checks++;
    if (lastHold != 3) begin failures++; $display("FAIL basic_hold: got %0d want 3 cycles", lastHold); end
    hostRead(3'd6, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL basic_status: got %h want 02", d); end
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h want a5", d); end
    waitIdle("basic_advance_idle");
    checks++;
    if (lastReqAddr !== 17'h00600) begin failures++; $display("FAIL basic_advance: got %h want 00600", lastReqAddr); end
  endtask

  task automatic test_advance_wrap();
    logic [7:0] d;
    hostWrite(3'd4, 8'h01);
    hostWrite(3'd2, 8'h00);
    hostWrite(3'd7, 8'h00);
    waitIdle("wrap_arm1_idle");
    checks++;
    if (lastReqAddr !== 17'h001FF) begin failures++; $display("FAIL wrap_arm1: got %h want 001ff", lastReqAddr); end
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL wrap_data1: got %h want a5", d); end
    waitIdle("wrap_carry_idle");
    checks++;
    if (lastReqAddr !== 17'h00200) begin failures++; $display("FAIL wrap_carry: got %h want 00200", lastReqAddr); end
    hostWrite(3'd2, 8'hFF);
    hostWrite(3'd7, 8'h00);
    waitIdle("wrap_arm2_idle");
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL wrap_data2: got %h want a5", d); end
    waitIdle("wrap_top_idle");
    checks++;
    if (lastReqAddr !== 17'h00000) begin failures++; $display("FAIL wrap_top: got %h want 00000", lastReqAddr); end
    hostWrite(3'd4, 8'h10);
    hostWrite(3'd0, 8'hF8);
    hostWrite(3'd7, 8'h00);
    waitIdle("wrap_arm3_idle");
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'hA2) begin failures++; $display("FAIL wrap_data3: got %h want a2", d); end
    waitIdle("wrap_inc16_idle");
    checks++;
    if (lastReqAddr !== 17'h00008) begin failures++; $display("FAIL wrap_inc16: got %h want 00008", lastReqAddr); end
  endtask

  task automatic test_read_while_busy();
    logic [7:0] d;
    int rc;
    memLatency = 10;
    hostWrite(3'd0, 8'h33);
    hostWrite(3'd1, 8'h00);
    hostWrite(3'd2, 8'h00);
    hostWrite(3'd7, 8'h00);
    rc = reqCount;
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'h52) begin failures++; $display("FAIL busy_stale_data: got %h want 52", d); end
    hostRead(3'd6, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL busy_status: got %h want 01", d); end
    waitIdle("busy_idle");
    checks++;
    if (reqCount != rc) begin failures++; $display("FAIL busy_no_extra_req: got %0d want %0d", reqCount, rc); end
    checks++;
    if (lastReqAddr !== 17'h00033) begin failures++; $display("FAIL busy_no_advance: got %h want 00033", lastReqAddr); end
    memLatency = 3;
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'h69) begin failures++; $display("FAIL busy_data: got %h want 69", d); end
    waitIdle("busy_advance_idle");
    checks++;
    if (lastReqAddr !== 17'h00043) begin failures++; $display("FAIL busy_advance: got %h want 00043", lastReqAddr); end
  endtask

  task automatic test_back_to_back_arm();
    logic [7:0] d;
    int rc;
    int n;
    memLatency = 20;
    hostWrite(3'd0, 8'h10);
    hostWrite(3'd7, 8'h00);
    rc = reqCount;
    hostWrite(3'd0, 8'h20);
    hostWrite(3'd7, 8'h00);
    n = 0;
    while (!memoryReadComplete && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL b2b_first_complete: waited %0d cycles, required completion", n); end
    tick();
    checks++;
    if (memoryReadRequest !== 1'b0) begin failures++; $display("FAIL b2b_gap: got req=%b want 0", memoryReadRequest); end
    tick();
    checks++;
    if (memoryReadRequest !== 1'b1 || memoryAddress !== 17'h00020) begin
      failures++;
      $display("FAIL b2b_reissue: got req=%b addr=%h want req=1 addr=00020", memoryReadRequest, memoryAddress);
    end
    checks++;
    if (reqCount != rc + 1) begin failures++; $display("FAIL b2b_req_count: got %0d want %0d", reqCount, rc + 1); end
    hostRead(3'd6, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL b2b_discarded: got status %h want 01", d); end
    waitIdle("b2b_idle");
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'h7A) begin failures++; $display("FAIL b2b_data: got %h want 7a", d); end
    waitIdle("b2b_advance_idle");
    memLatency = 3;
  endtask

  task automatic test_reset_mid_request();
    logic [7:0] d;
    int rc;
    memLatency = 10;
    hostWrite(3'd0, 8'h40);
    hostWrite(3'd7, 8'h00);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (memoryReadRequest !== 1'b0) begin failures++; $display("FAIL midreset_req: got %b want 0", memoryReadRequest); end
    checks++;
    if (memoryAddress !== 17'h0) begin failures++; $display("FAIL midreset_addr: got %h want 00000", memoryAddress); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    hostRead(3'd6, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL midreset_status: got %h want 00", d); end
    hostRead(3'd5, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL midreset_databuf: got %h want 00", d); end
    rc = reqCount;
    repeat (20) tick();
    checks++;
    if (reqCount != rc || memoryReadRequest !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_fetch: got reqs=%0d req=%b want reqs=%0d req=0", reqCount, memoryReadRequest, rc);
    end
    memLatency = 3;
  endtask

  task automatic test_write_no_drive();
    for (int s = 0; s < 8; s++) begin
      mpuChipSelect = 1'b1; mpuWriteEnable = 1'b0; mpuRegisterSelect = 3'(s); tbDrive = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (mpuDataBus !== 8'hFF) begin
          failures++;
          $display("FAIL write_no_drive sel=%0d: got %h want ff (released)", s, mpuDataBus);
        end
      end
      mpuChipSelect = 1'b0;
      repeat (4) tick();
    end
    waitIdle("write_no_drive_idle");
  endtask

  initial begin
    reset = 1'b1;
    mpuChipSelect = 1'b0;
    mpuWriteEnable = 1'b0;
    mpuRegisterSelect = 3'd0;
    tbDrive = 1'b0;
    tbData = 8'h00;
    test_reset();
    test_basic_fetch();
    test_advance_wrap();
    test_read_while_busy();
    test_back_to_back_arm();
    test_reset_mid_request();
    test_write_no_drive();
    checks++;
    if (stabErr != 0) begin failures++; $display("FAIL addr_stable: got %0d changes want 0", stabErr); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
